// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg : shared fetch constants and fetch state encoding
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_FETCH = 2'd1,
    FS_DROP  = 2'd2
  } fetch_state_e;

  // The fetch state is fully implied by the outstanding/drop flag pair.
  function automatic fetch_state_e fetch_state(input logic outstanding, input logic drop);
    if (!outstanding) return FS_IDLE;
    if (drop)         return FS_DROP;
    return FS_FETCH;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_skid_buffer.sv
// ---------------------------------------------------------------------------
// fetch_skid_buffer : one-entry instr/PC holding register (clear > load > drain)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_skid_buffer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        drain_i,
  input  logic        clear_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= 1'b0;
      instr_q <= 32'd0;
      pc_q    <= 32'd0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

`default_nettype wire

// File: rtl/fetch_redirect_unit.sv
// ---------------------------------------------------------------------------
// fetch_redirect_unit : fetch PC, imem handshake, skid buffer and IF/ID register
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_redirect_unit #(
  parameter logic [31:0] RESET_PC  = cpu_pkg::RESET_PC,
  parameter logic [31:0] PC_STEP   = cpu_pkg::PC_STEP,
  parameter logic [31:0] INSTR_NOP = cpu_pkg::INSTR_NOP
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] target_PC_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_PC_o,
  output logic        instr_valid_o
);
  import cpu_pkg::*;

  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic         outstanding_q, outstanding_d;
  logic         drop_q, drop_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic         instr_valid_q, instr_valid_d;

  fetch_state_e state;
  logic         issue;
  logic         req_active;
  logic [31:0]  cur_addr;
  logic         skid_valid, skid_load, skid_drain, skid_clear;
  logic [31:0]  skid_instr, skid_pc;

  // Issue is gated by rst_i so the combinational request stays low during reset.
  always_comb begin
    state      = fetch_state(outstanding_q, drop_q);
    issue      = rst_i && (state == FS_IDLE) && start_i && !stall_i && !flush_i && !skid_valid;
    req_active = (state != FS_IDLE) || issue;
    cur_addr   = (state == FS_IDLE) ? pc_q : req_addr_q;
  end

  always_comb begin
    pc_d          = pc_q;
    req_addr_d    = req_addr_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    skid_load     = 1'b0;
    skid_drain    = 1'b0;
    skid_clear    = 1'b0;

    if (flush_i) begin
      pc_d          = target_PC_i;
      instr_valid_d = 1'b0;
      instr_d       = INSTR_NOP;
      skid_clear    = 1'b1;
      outstanding_d = req_active && !imem_ack_i;
      drop_d        = req_active && !imem_ack_i;
    end else begin
      if (issue) begin
        pc_d       = pc_q + PC_STEP;
        req_addr_d = pc_q;
      end
      if (req_active && imem_ack_i) begin
        outstanding_d = 1'b0;
        drop_d        = 1'b0;
        if (state != FS_DROP) begin
          if (stall_i) begin
            skid_load = 1'b1;
          end else begin
            instr_d       = imem_data_i;
            instr_pc_d    = cur_addr;
            instr_valid_d = 1'b1;
          end
        end
      end else if (issue) begin
        outstanding_d = 1'b1;
        drop_d        = 1'b0;
      end
      // A full skid implies no request in flight, so this never races an ack.
      if (!stall_i && skid_valid) begin
        skid_drain    = 1'b1;
        instr_d       = skid_instr;
        instr_pc_d    = skid_pc;
        instr_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q          <= RESET_PC;
      req_addr_q    <= RESET_PC;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      instr_q       <= INSTR_NOP;
      instr_pc_q    <= 32'd0;
      instr_valid_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      req_addr_q    <= req_addr_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  fetch_skid_buffer u_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (skid_load),
    .drain_i (skid_drain),
    .clear_i (skid_clear),
    .instr_i (imem_data_i),
    .pc_i    (cur_addr),
    .valid_o (skid_valid),
    .instr_o (skid_instr),
    .pc_o    (skid_pc)
  );

  assign imem_req_o    = req_active;
  assign imem_addr_o   = cur_addr;
  assign instr_o       = instr_q;
  assign instr_PC_o    = instr_pc_q;
  assign instr_valid_o = instr_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_redirect_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_redirect_unit : directed vector table, reset sequence, random run
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fetch_redirect_unit;
  import cpu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] target_PC_i = 32'd0;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_data_i = 32'd0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] instr_o;
  logic [31:0] instr_PC_o;
  logic        instr_valid_o;

  fetch_redirect_unit dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .target_PC_i   (target_PC_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_data_i   (imem_data_i),
    .instr_o       (instr_o),
    .instr_PC_o    (instr_PC_o),
    .instr_valid_o (instr_valid_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic req, input logic [31:0] addr,
                            input logic valid, input logic [31:0] pc, input logic [31:0] ins);
    check({tag, ".req"},   {31'd0, imem_req_o},    {31'd0, req});
    check({tag, ".addr"},  imem_addr_o,            addr);
    check({tag, ".valid"}, {31'd0, instr_valid_o}, {31'd0, valid});
    check({tag, ".pc"},    instr_PC_o,             pc);
    check({tag, ".instr"}, instr_o,                ins);
  endtask

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'hC000_0000;
  endfunction

  typedef struct {
    logic        start;
    logic        stall;
    logic        flush;
    logic [31:0] tgt;
    logic        ack;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  function automatic vec_t v(input logic st, input logic sl, input logic fl, input logic [31:0] tg,
                             input logic ak, input logic rq, input logic [31:0] ad,
                             input logic vl, input logic [31:0] pc);
    vec_t r;
    r.start = st; r.stall = sl; r.flush = fl; r.tgt = tg; r.ack = ak;
    r.exp_req = rq; r.exp_addr = ad; r.exp_valid = vl; r.exp_pc = pc;
    return r;
  endfunction

  localparam int NVEC = 25;
  vec_t vt [NVEC];

  // Reference model state: transaction-level view of the fetch unit.
  typedef struct { logic [31:0] addr; logic stale; } fly_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
  fly_t        fly_q [$];
  ent_t        skid_q [$];
  fly_t        f;
  ent_t        e;
  logic [31:0] m_pc, m_addr, ifid_instr, ifid_pc;
  logic        ifid_valid, m_issue, m_active;
  int          m_lat, m_wait;

  initial begin
    // start, stall, flush, target, ack | req, addr, valid, IF/ID pc
    vt[0]  = v(1,0,0,32'h0,1,        1,32'h0,0,32'h0);
    vt[1]  = v(1,0,0,32'h0,1,        1,32'h4,1,32'h0);
    vt[2]  = v(1,0,0,32'h0,1,        1,32'h8,1,32'h4);
    vt[3]  = v(1,0,0,32'h0,1,        1,32'hC,1,32'h8);
    vt[4]  = v(1,0,0,32'h0,0,        1,32'h10,1,32'hC);
    vt[5]  = v(1,1,0,32'h0,1,        1,32'h10,1,32'hC);
    vt[6]  = v(1,1,0,32'h0,0,        0,32'h14,1,32'hC);
    vt[7]  = v(1,1,0,32'h0,0,        0,32'h14,1,32'hC);
    vt[8]  = v(1,0,0,32'h0,0,        0,32'h14,1,32'hC);
    vt[9]  = v(1,0,0,32'h0,0,        1,32'h14,1,32'h10);
    vt[10] = v(1,0,1,32'h40,0,       1,32'h14,1,32'h10);
    vt[11] = v(1,0,0,32'h0,1,        1,32'h14,0,32'h10);
    vt[12] = v(1,0,0,32'h0,0,        1,32'h40,0,32'h10);
    vt[13] = v(1,0,0,32'h0,1,        1,32'h40,0,32'h10);
    vt[14] = v(1,0,0,32'h0,0,        1,32'h44,1,32'h40);
    vt[15] = v(1,0,1,32'h100,1,      1,32'h44,1,32'h40);
    vt[16] = v(1,0,0,32'h0,1,        1,32'h100,0,32'h40);
    vt[17] = v(0,0,0,32'h0,0,        0,32'h104,1,32'h100);
    vt[18] = v(1,0,0,32'h0,0,        1,32'h104,1,32'h100);
    vt[19] = v(1,1,0,32'h0,1,        1,32'h104,1,32'h100);
    vt[20] = v(1,1,1,32'h200,0,      0,32'h108,1,32'h100);
    vt[21] = v(1,0,0,32'h0,0,        1,32'h200,0,32'h100);
    vt[22] = v(1,0,1,32'hFFFF_FFFC,1,1,32'h200,0,32'h100);
    vt[23] = v(1,0,0,32'h0,1,        1,32'hFFFF_FFFC,0,32'h100);
    vt[24] = v(1,0,0,32'h0,0,        1,32'h0,1,32'hFFFF_FFFC);

    repeat (2) @(negedge clk_i);
    #1 check_outs("reset", 1'b0, RESET_PC, 1'b0, 32'd0, INSTR_NOP);
    @(negedge clk_i);
    rst_i = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk_i);
      start_i     = vt[i].start;
      stall_i     = vt[i].stall;
      flush_i     = vt[i].flush;
      target_PC_i = vt[i].tgt;
      imem_ack_i  = vt[i].ack;
      imem_data_i = vt[i].ack ? dat(vt[i].exp_addr) : 32'hDEAD_BEEF;
      #1 check_outs($sformatf("vec%0d", i), vt[i].exp_req, vt[i].exp_addr, vt[i].exp_valid,
                    vt[i].exp_pc, vt[i].exp_valid ? dat(vt[i].exp_pc) : INSTR_NOP);
    end

    // Reset while the request for address 0 is outstanding, then a late ack.
    @(negedge clk_i);
    imem_ack_i = 1'b0;
    stall_i    = 1'b0;
    flush_i    = 1'b0;
    #2 rst_i = 1'b0;
    #1 check_outs("rst_async", 1'b0, RESET_PC, 1'b0, 32'd0, INSTR_NOP);
    @(negedge clk_i);
    imem_ack_i = 1'b1;
    #1 check_outs("rst_hold", 1'b0, RESET_PC, 1'b0, 32'd0, INSTR_NOP);
    @(negedge clk_i);
    rst_i = 1'b1; start_i = 1'b0; imem_ack_i = 1'b1; imem_data_i = 32'h1234_5678;
    #1 check_outs("rst_late_ack", 1'b0, RESET_PC, 1'b0, 32'd0, INSTR_NOP);
    @(negedge clk_i);
    start_i = 1'b1; imem_ack_i = 1'b1; imem_data_i = dat(RESET_PC);
    #1 check_outs("rst_first_issue", 1'b1, RESET_PC, 1'b0, 32'd0, INSTR_NOP);
    @(negedge clk_i);
    start_i = 1'b0; imem_ack_i = 1'b0;
    #1 check_outs("rst_first_valid", 1'b0, RESET_PC + PC_STEP, 1'b1, RESET_PC, dat(RESET_PC));

    // Randomized run against the reference model.
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    rst_i      = 1'b1;
    m_pc       = RESET_PC;
    ifid_valid = 1'b0;
    ifid_instr = INSTR_NOP;
    ifid_pc    = 32'd0;
    fly_q.delete();
    skid_q.delete();
    m_lat  = 0;
    m_wait = 0;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_i);
      start_i     = ($urandom_range(0, 7) != 0);
      stall_i     = ($urandom_range(0, 3) == 0);
      flush_i     = ($urandom_range(0, 11) == 0);
      target_PC_i = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF8 + $urandom_range(0, 1) * 4) : $urandom;
      m_issue  = (fly_q.size() == 0) && start_i && !stall_i && !flush_i && (skid_q.size() == 0);
      m_active = (fly_q.size() != 0) || m_issue;
      m_addr   = (fly_q.size() != 0) ? fly_q[0].addr : m_pc;
      if (m_issue) begin
        m_lat  = $urandom_range(0, 2);
        m_wait = 0;
      end
      imem_ack_i  = m_active ? (m_wait >= m_lat) : ($urandom_range(0, 7) == 0);
      imem_data_i = $urandom;
      #1 check_outs($sformatf("rnd%0d", c), m_active, m_addr, ifid_valid, ifid_pc, ifid_instr);

      @(posedge clk_i);
      if (flush_i) begin
        ifid_valid = 1'b0;
        ifid_instr = INSTR_NOP;
        skid_q.delete();
        m_pc = target_PC_i;
        if (m_active && !imem_ack_i) begin
          f = fly_q.pop_front();
          f.stale = 1'b1;
          fly_q.push_back(f);
          m_wait++;
        end else begin
          fly_q.delete();
        end
      end else begin
        if (m_issue) m_pc = m_pc + PC_STEP;
        if (m_active && imem_ack_i) begin
          if (fly_q.size() == 0 || !fly_q[0].stale) begin
            if (stall_i) begin
              e.instr = imem_data_i;
              e.pc    = m_addr;
              skid_q.push_back(e);
            end else begin
              ifid_valid = 1'b1;
              ifid_instr = imem_data_i;
              ifid_pc    = m_addr;
            end
          end
          fly_q.delete();
        end else if (m_active) begin
          if (fly_q.size() == 0) begin
            f.addr  = m_addr;
            f.stale = 1'b0;
            fly_q.push_back(f);
          end
          m_wait++;
        end
        if (!stall_i && skid_q.size() != 0) begin
          e = skid_q.pop_front();
          ifid_valid = 1'b1;
          ifid_instr = e.instr;
          ifid_pc    = e.pc;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
